fb_swap_controller: RTL and testbench

//  Parametrised successor of the 640x480 double-buffer controller: manages NUM_BUF (2 or 3) frame buffers
//  in one flat memory, auto-clears the draw buffer, and swaps display/draw roles only on a v_sync rising edge.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/fb_clear_engine.sv | 42 ++++
 rtl/fb_swap_controller.sv | 202 ++++++++++++++++++++
 tb/tb_fb_swap_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared state encodings and width helpers for the frame-buffer swap controller.
package fb_pkg;

    localparam logic [1:0] ST_CLEAR   = 2'd0;
    localparam logic [1:0] ST_DRAW    = 2'd1;
    localparam logic [1:0] ST_WAIT_VS = 2'd2;

    // Smallest width able to index v distinct values
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Buffer index width: 1 bit for double, 2 bits for triple buffering
    function automatic int unsigned buf_width(input int unsigned nb);
        return (nb > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Sweeps one buffer with CLEAR_COLOR, one pixel per cycle while start is held.
module fb_clear_engine
    import fb_pkg::*;
#(
    parameter int unsigned PIXELS      = 307200,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned BUF_W       = 1,
    parameter int unsigned CLR_BITS    = 6,
    parameter int unsigned CLEAR_COLOR = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BUF_W-1:0]          buf_idx,
    output logic                      clr_we_c,
    output logic [BUF_W+ADDR_W-1:0]   clr_addr_c,
    output logic [CLR_BITS-1:0]       clr_data_c,
    output logic                      done_c
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    // Counter advances while clearing and returns to zero otherwise or after the last pixel
    always_comb begin
        clr_cnt_d = '0;
        if (start && (clr_cnt_q != LAST)) clr_cnt_d = clr_cnt_q + ADDR_W'(1);
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clr_cnt_q <= '0;
        else        clr_cnt_q <= clr_cnt_d;
    end

    assign clr_we_c   = start;
    assign clr_addr_c = {buf_idx, clr_cnt_q};
    assign clr_data_c = CLR_BITS'(CLEAR_COLOR);
    assign done_c     = start && (clr_cnt_q == LAST);

endmodule

// File: rtl/fb_swap_controller.sv
// Double/triple frame-buffer controller: clears the draw buffer, muxes clear and
// drawer writes onto one registered write port, and swaps roles on v_sync rising edges.
module fb_swap_controller
    import fb_pkg::*;
#(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned CLR_BITS    = 6,
    parameter int unsigned NUM_BUF     = 2,
    parameter int unsigned CLEAR_COLOR = 0,
    localparam int unsigned PIXELS     = H_RES * V_RES,
    localparam int unsigned ADDR_W     = clog2(PIXELS),
    localparam int unsigned BUF_W      = buf_width(NUM_BUF)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      v_sync,
    input  logic                      clear_en,
    input  logic                      frame_done,
    input  logic                      draw_we,
    input  logic [ADDR_W-1:0]         draw_addr,
    input  logic [CLR_BITS-1:0]       draw_data,
    output logic                      draw_ready,
    input  logic [ADDR_W-1:0]         vga_addr,
    output logic [BUF_W+ADDR_W-1:0]   rd_addr,
    output logic                      wr_en,
    output logic [BUF_W+ADDR_W-1:0]   wr_addr,
    output logic [CLR_BITS-1:0]       wr_data,
    output logic                      draw_err,
    output logic [15:0]               frame_cnt
);

    logic [1:0]                state_q, state_d;
    logic [BUF_W-1:0]          disp_q, disp_d;
    logic [BUF_W-1:0]          draw_q, draw_d;
    logic [BUF_W-1:0]          pend_q, pend_d;
    logic                      pend_valid_q, pend_valid_d;
    logic                      vs_q;
    logic                      wr_en_q, wr_en_d;
    logic [BUF_W+ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [CLR_BITS-1:0]       wr_data_q, wr_data_d;
    logic                      draw_ready_q, draw_ready_d;
    logic                      draw_err_q, draw_err_d;
    logic [15:0]               frame_cnt_q, frame_cnt_d;

    logic                      vs_rise_c;
    logic                      draw_ok_c;
    logic                      clr_start_c;
    logic                      clr_we_c;
    logic [BUF_W+ADDR_W-1:0]   clr_addr_c;
    logic [CLR_BITS-1:0]       clr_data_c;
    logic                      clr_done_c;

    assign vs_rise_c   = v_sync & ~vs_q;
    assign draw_ok_c   = draw_we && draw_ready_q && (32'(draw_addr) < PIXELS);
    assign clr_start_c = (state_q == ST_CLEAR) && clear_en;

    fb_clear_engine #(
        .PIXELS      (PIXELS),
        .ADDR_W      (ADDR_W),
        .BUF_W       (BUF_W),
        .CLR_BITS    (CLR_BITS),
        .CLEAR_COLOR (CLEAR_COLOR)
    ) u_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (clr_start_c),
        .buf_idx    (draw_q),
        .clr_we_c   (clr_we_c),
        .clr_addr_c (clr_addr_c),
        .clr_data_c (clr_data_c),
        .done_c     (clr_done_c)
    );

    // Role FSM, write mux and counters
    always_comb begin
        state_d      = state_q;
        disp_d       = disp_q;
        draw_d       = draw_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        draw_err_d   = draw_err_q;
        frame_cnt_d  = frame_cnt_q;

        // Clear and draw never overlap: clear runs only in CLEAR, draws only when ready
        if (clr_we_c) begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_addr_c;
            wr_data_d = clr_data_c;
        end else if (draw_ok_c) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {draw_q, draw_addr};
            wr_data_d = draw_data;
        end
        if (draw_we && !draw_ok_c) draw_err_d = 1'b1;

        case (state_q)
            ST_CLEAR: begin
                if (!clear_en || clr_done_c) state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (frame_done) begin
                    if (NUM_BUF == 2) begin
                        if (vs_rise_c) begin
                            disp_d      = draw_q;
                            draw_d      = disp_q;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            state_d     = ST_CLEAR;
                        end else begin
                            state_d = ST_WAIT_VS;
                        end
                    end else if (vs_rise_c) begin
                        // Fresh frame shown at once; any older pending frame is discarded
                        disp_d       = draw_q;
                        draw_d       = disp_q;
                        pend_valid_d = 1'b0;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        state_d      = ST_CLEAR;
                    end else if (!pend_valid_q) begin
                        // Indices 0..2 sum to 3, so the free buffer is the remainder
                        pend_d       = draw_q;
                        pend_valid_d = 1'b1;
                        draw_d       = BUF_W'(3) - disp_q - draw_q;
                        state_d      = ST_CLEAR;
                    end else begin
                        state_d = ST_WAIT_VS;
                    end
                end
            end
            ST_WAIT_VS: begin
            end
            default: state_d = ST_CLEAR;
        endcase

        // Swaps on v_sync not already handled by the frame_done path above
        if (vs_rise_c && !((state_q == ST_DRAW) && frame_done)) begin
            if (NUM_BUF == 2) begin
                if (state_q == ST_WAIT_VS) begin
                    disp_d      = draw_q;
                    draw_d      = disp_q;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_CLEAR;
                end
            end else if (pend_valid_q) begin
                disp_d       = pend_q;
                pend_valid_d = 1'b0;
                frame_cnt_d  = frame_cnt_q + 16'd1;
                if (state_q == ST_WAIT_VS) begin
                    pend_d       = draw_q;
                    pend_valid_d = 1'b1;
                    draw_d       = disp_q;
                    state_d      = ST_CLEAR;
                end
            end
        end

        draw_ready_d = (state_d == ST_DRAW);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            disp_q       <= '0;
            draw_q       <= BUF_W'(1);
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            vs_q         <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            draw_ready_q <= 1'b0;
            draw_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            disp_q       <= disp_d;
            draw_q       <= draw_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            vs_q         <= v_sync;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            draw_ready_q <= draw_ready_d;
            draw_err_q   <= draw_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign rd_addr    = {disp_q, vga_addr};
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign draw_ready = draw_ready_q;
    assign draw_err   = draw_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fb_swap_controller.sv
// Directed bench: double-buffer instance (4x2) and triple-buffer instance (3x3).
module tb_fb_swap_controller;

    logic clk;
    int   checks;
    int   errors;

    // Double-buffer DUT: PIXELS=8, ADDR_W=3, BUF_W=1
    logic        rst2_n, vs2, ce2, fd2, we2, rdy2, wen2, err2;
    logic [2:0]  da2, vga2;
    logic [5:0]  dd2, wd2;
    logic [3:0]  rd2, wa2;
    logic [15:0] fc2;

    // Triple-buffer DUT: PIXELS=9, ADDR_W=4, BUF_W=2
    logic        rst3_n, vs3, ce3, fd3, we3, rdy3, wen3, err3;
    logic [3:0]  da3, vga3;
    logic [5:0]  dd3, wd3;
    logic [5:0]  rd3, wa3;
    logic [15:0] fc3;

    fb_swap_controller #(.H_RES(4), .V_RES(2), .CLR_BITS(6), .NUM_BUF(2), .CLEAR_COLOR(0)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .v_sync(vs2), .clear_en(ce2), .frame_done(fd2),
        .draw_we(we2), .draw_addr(da2), .draw_data(dd2), .draw_ready(rdy2),
        .vga_addr(vga2), .rd_addr(rd2), .wr_en(wen2), .wr_addr(wa2), .wr_data(wd2),
        .draw_err(err2), .frame_cnt(fc2)
    );

    fb_swap_controller #(.H_RES(3), .V_RES(3), .CLR_BITS(6), .NUM_BUF(3), .CLEAR_COLOR(0)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .v_sync(vs3), .clear_en(ce3), .frame_done(fd3),
        .draw_we(we3), .draw_addr(da3), .draw_data(dd3), .draw_ready(rdy3),
        .vga_addr(vga3), .rd_addr(rd3), .wr_en(wen3), .wr_addr(wa3), .wr_data(wd3),
        .draw_err(err3), .frame_cnt(fc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst2_n = 1'b0; vs2 = 1'b0; ce2 = 1'b1; fd2 = 1'b0; we2 = 1'b0; da2 = '0; dd2 = '0; vga2 = 3'd3;
        rst3_n = 1'b0; vs3 = 1'b0; ce3 = 1'b1; fd3 = 1'b0; we3 = 1'b0; da3 = '0; dd3 = '0; vga3 = 4'd3;

        // ---------------- double buffer ----------------
        repeat (3) tick();
        chk("rst_wr_en",      32'(wen2), 32'd0);
        chk("rst_wr_addr",    32'(wa2),  32'd0);
        chk("rst_draw_ready", 32'(rdy2), 32'd0);
        chk("rst_draw_err",   32'(err2), 32'd0);
        chk("rst_frame_cnt",  32'(fc2),  32'd0);
        chk("rst_rd_addr",    32'(rd2),  32'd3);

        rst2_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("clr_wr_en",   32'(wen2), 32'd1);
            chk("clr_wr_addr", 32'(wa2),  32'(8 + i));
            chk("clr_wr_data", 32'(wd2),  32'd0);
            chk("clr_ready",   32'(rdy2), (i == 7) ? 32'd1 : 32'd0);
        end
        tick();
        chk("draw_idle_wr_en", 32'(wen2), 32'd0);
        chk("draw_idle_ready", 32'(rdy2), 32'd1);

        we2 = 1'b1; da2 = 3'd5; dd2 = 6'h2A;
        tick();
        we2 = 1'b0;
        chk("draw_wr_en",   32'(wen2), 32'd1);
        chk("draw_wr_addr", 32'(wa2),  32'd13);
        chk("draw_wr_data", 32'(wd2),  32'h2A);
        chk("draw_no_err",  32'(err2), 32'd0);

        fd2 = 1'b1;
        tick();
        fd2 = 1'b0;
        chk("wait_ready", 32'(rdy2), 32'd0);
        chk("wait_wr_en", 32'(wen2), 32'd0);
        chk("wait_fcnt",  32'(fc2),  32'd0);
        repeat (19) tick();
        chk("wait_rd_addr", 32'(rd2), 32'd3);
        vs2 = 1'b1;
        tick();
        chk("swap_rd_addr", 32'(rd2), 32'd11);
        chk("swap_fcnt",    32'(fc2), 32'd1);

        // A write attempted during the clear must be dropped and flagged
        we2 = 1'b1; da2 = 3'd2; dd2 = 6'h11;
        tick();
        we2 = 1'b0;
        chk("clr0_wr_en",   32'(wen2), 32'd1);
        chk("clr0_wr_addr", 32'(wa2),  32'd0);
        chk("clr0_wr_data", 32'(wd2),  32'd0);
        chk("busy_err",     32'(err2), 32'd1);
        repeat (6) tick();
        chk("clr0_not_ready", 32'(rdy2), 32'd0);
        tick();
        chk("clr0_last_addr", 32'(wa2),  32'd7);
        chk("clr0_ready",     32'(rdy2), 32'd1);
        chk("err_sticky",     32'(err2), 32'd1);

        // frame_done coinciding with vs_rise swaps directly into CLEAR
        vs2 = 1'b0;
        tick();
        fd2 = 1'b1; vs2 = 1'b1;
        tick();
        fd2 = 1'b0;
        chk("same_fcnt",    32'(fc2),  32'd2);
        chk("same_rd_addr", 32'(rd2),  32'd3);
        chk("same_ready",   32'(rdy2), 32'd0);
        tick();
        chk("same_clr_en",   32'(wen2), 32'd1);
        chk("same_clr_addr", 32'(wa2),  32'd8);
        tick();
        tick();
        chk("midclr_addr", 32'(wa2), 32'd10);

        // Asynchronous reset in the middle of a clear
        #2 rst2_n = 1'b0;
        #1;
        chk("arst_wr_en",   32'(wen2), 32'd0);
        chk("arst_wr_addr", 32'(wa2),  32'd0);
        chk("arst_fcnt",    32'(fc2),  32'd0);
        chk("arst_err",     32'(err2), 32'd0);
        chk("arst_rd_addr", 32'(rd2),  32'd3);
        #2 rst2_n = 1'b1;
        tick();
        chk("restart_wr_en",   32'(wen2), 32'd1);
        chk("restart_wr_addr", 32'(wa2),  32'd8);

        // clear_en=0 skips straight to DRAW
        rst2_n = 1'b0; ce2 = 1'b0;
        #1 rst2_n = 1'b1;
        tick();
        chk("skip_ready", 32'(rdy2), 32'd1);
        chk("skip_wr_en", 32'(wen2), 32'd0);

        // ---------------- triple buffer ----------------
        chk("t_rst_rd_addr", 32'(rd3), 32'd3);
        rst3_n = 1'b1;
        repeat (8) tick();
        chk("t_clr_not_ready", 32'(rdy3), 32'd0);
        tick();
        chk("t_clr_ready",     32'(rdy3), 32'd1);
        chk("t_clr_last_addr", 32'(wa3),  32'd24);

        we3 = 1'b1; da3 = 4'd9; dd3 = 6'h3F;
        tick();
        chk("t_oor_wr_en", 32'(wen3), 32'd0);
        chk("t_oor_err",   32'(err3), 32'd1);
        da3 = 4'd4; dd3 = 6'h15;
        tick();
        we3 = 1'b0;
        chk("t_draw_wr_en",   32'(wen3), 32'd1);
        chk("t_draw_wr_addr", 32'(wa3),  32'd20);
        chk("t_draw_wr_data", 32'(wd3),  32'h15);

        // frame_done without vs: frame becomes pending, buffer 2 cleared at once
        fd3 = 1'b1;
        tick();
        fd3 = 1'b0;
        chk("t_pend_ready", 32'(rdy3), 32'd0);
        tick();
        chk("t_clr2_wr_en",   32'(wen3), 32'd1);
        chk("t_clr2_wr_addr", 32'(wa3),  32'd32);
        chk("t_pre_vs_rd",    32'(rd3),  32'd3);
        vs3 = 1'b1;
        tick();
        chk("t_vs_rd_addr",   32'(rd3), 32'd19);
        chk("t_vs_fcnt",      32'(fc3), 32'd1);
        chk("t_clr2_addr1",   32'(wa3), 32'd33);
        tick();
        chk("t_clr2_addr2",   32'(wa3), 32'd34);

        // Second vs_rise with nothing pending changes nothing
        vs3 = 1'b0;
        tick();
        vs3 = 1'b1;
        tick();
        chk("t_nopend_fcnt", 32'(fc3), 32'd1);
        chk("t_nopend_rd",   32'(rd3), 32'd19);
        repeat (4) tick();
        chk("t_clr2_done_ready", 32'(rdy3), 32'd1);
        chk("t_clr2_last_addr",  32'(wa3),  32'd40);

        // Next pending frame: free buffer is 0 (disp=1, draw=2)
        fd3 = 1'b1;
        tick();
        fd3 = 1'b0;
        chk("t_pend2_fcnt", 32'(fc3), 32'd1);
        tick();
        chk("t_clr0_wr_en",   32'(wen3), 32'd1);
        chk("t_clr0_wr_addr", 32'(wa3),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
